// File: rtl/ddr3_sniff_reader_pkg.sv
// Shared DDR3 command codes, beat geometry and reader state encoding for the
// sniff reader and its beat buffer.
package ddr3_sniff_reader_pkg;

    localparam logic [2:0] DDR3_CMD_WRITE = 3'b000;
    localparam logic [2:0] DDR3_CMD_READ  = 3'b001;

    localparam int BEAT_W         = 288;
    localparam int MASK_W         = 36;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_BEAT = BEAT_W / WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } sniff_state_e;

endpackage

// File: rtl/ddr3_beat_buffer.sv
// Capture storage for one read burst: BEATS x 288-bit slots written a beat at a
// time, read back as 32-bit words through a registered port.
module ddr3_beat_buffer
    import ddr3_sniff_reader_pkg::*;
#(
    parameter int BEATS = 2,
    parameter int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic [4:0]        rd_sel,
    output logic [WORD_W-1:0] rd_word
);

    localparam int NWORDS = WORDS_PER_BEAT * BEATS;

    logic [BEAT_W-1:0]        mem_q [BEATS];
    logic [NWORDS*WORD_W-1:0] flat;
    logic [WORD_W-1:0]        rd_word_d;
    logic [WORD_W-1:0]        rd_word_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Beat 0 occupies the least significant end of the word space.
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_flat
        assign flat[gi*BEAT_W +: BEAT_W] = mem_q[gi];
    end

    // Selects beyond the captured words read as zero.
    always_comb begin
        rd_word_d = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (32'(rd_sel) == w) begin
                rd_word_d = flat[w*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            rd_word_q <= '0;
        end else begin
            rd_word_q <= rd_word_d;
        end
    end

    assign rd_word = rd_word_q;

endmodule

// File: rtl/ddr3_sniff_reader.sv
// Issues one DDR3 read burst on the arbiter's low-priority port per request and
// captures the returned beats for word-wise readback, with a cycle timeout.
module ddr3_sniff_reader
    import ddr3_sniff_reader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int BEATS          = 2
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [31:0]       req_addr,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    input  logic [4:0]        rd_word_sel,
    output logic [31:0]       rd_word,
    output logic [2:0]        sniff_cmd,
    output logic [31:0]       sniff_addr,
    output logic              sniff_en,
    output logic [BEAT_W-1:0] sniff_wdf_data,
    output logic [MASK_W-1:0] sniff_wdf_mask,
    output logic              sniff_wdf_end,
    output logic              sniff_wdf_wren,
    input  logic              sniff_rdy,
    input  logic              sniff_wdf_rdy,
    input  logic [BEAT_W-1:0] sniff_rd_data,
    input  logic              sniff_rd_data_valid,
    input  logic              sniff_rd_data_end
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BEATS_C  = CNT_W'(BEATS);

    sniff_state_e     state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_timeout_q, err_timeout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             sniff_en_q, sniff_en_d;
    logic             req_ready_q, req_ready_d;
    logic             beat_wr_en;
    logic [3:0]       unused_bits;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_cnt_d    = beat_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        err_timeout_d = err_timeout_q;
        beat_wr_en    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (req_valid) begin
                    addr_d        = {req_addr[31:3], 3'b000};
                    beat_cnt_d    = '0;
                    tmo_cnt_d     = '0;
                    err_timeout_d = 1'b0;
                    state_d       = ST_CMD;
                end
            end
            ST_CMD: begin
                if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = ST_DONE;
                    err_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (sniff_rdy) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Extra beats beyond the buffer depth are dropped; the count saturates.
                if (sniff_rd_data_valid && (beat_cnt_q < BEATS_C)) begin
                    beat_wr_en = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // A burst end takes priority over a timeout landing in the same cycle.
                if (sniff_rd_data_valid && sniff_rd_data_end) begin
                    state_d = ST_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = ST_DONE;
                    err_timeout_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d      = (state_d == ST_CMD) || (state_d == ST_WAIT);
        done_d      = (state_d == ST_DONE);
        sniff_en_d  = (state_d == ST_CMD);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            beat_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            err_timeout_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            sniff_en_q    <= 1'b0;
            req_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            beat_cnt_q    <= beat_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            err_timeout_q <= err_timeout_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            sniff_en_q    <= sniff_en_d;
            req_ready_q   <= req_ready_d;
        end
    end

    ddr3_beat_buffer #(
        .BEATS (BEATS),
        .IDX_W (IDX_W)
    ) u_buf (
        .clk     (clk),
        .Reset   (Reset),
        .wr_en   (beat_wr_en),
        .wr_idx  (beat_cnt_q[IDX_W-1:0]),
        .wr_data (sniff_rd_data),
        .rd_sel  (rd_word_sel),
        .rd_word (rd_word)
    );

    assign req_ready      = req_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_timeout    = err_timeout_q;
    assign sniff_en       = sniff_en_q;
    assign sniff_cmd      = DDR3_CMD_READ;
    assign sniff_addr     = addr_q;
    assign sniff_wdf_data = '0;
    assign sniff_wdf_mask = '1;
    assign sniff_wdf_end  = 1'b0;
    assign sniff_wdf_wren = 1'b0;

    // This port only reads; write-data readiness and the sub-beat address bits are ignored.
    assign unused_bits = {sniff_wdf_rdy, req_addr[2:0]};

endmodule
